// File: rtl/div_issue_ctrl_if.sv
// Handshake and data bundle between the scheduler, the iterative divider and
// the writeback arbiter on one side and div_issue_ctrl on the other.
// The controller uses the slave view; the surrounding pipeline uses master.
interface div_issue_ctrl_if #(
    parameter int LG_W           = 5,
    parameter int LG_ROB_ENTRIES = 6,
    parameter int LG_PRF_ENTRIES = 7
);
    localparam int W = 1 << LG_W;

    // Scheduler -> queue
    logic                      enq_valid;
    logic                      enq_ready;
    logic [W-1:0]              enq_srcA;
    logic [W-1:0]              enq_srcB;
    logic                      enq_signed;
    logic                      enq_rem;
    logic [LG_ROB_ENTRIES-1:0] enq_rob_ptr;
    logic [LG_PRF_ENTRIES-1:0] enq_prf_ptr;

    // Controller -> divider
    logic                      start_div;
    logic [W-1:0]              div_srcA;
    logic [W-1:0]              div_srcB;
    logic                      div_is_signed;
    logic                      div_is_rem;
    logic [LG_ROB_ENTRIES-1:0] div_rob_ptr;
    logic [LG_PRF_ENTRIES-1:0] div_prf_ptr;

    // Divider -> controller
    logic                      div_complete;
    logic [2*W-1:0]            div_y;
    logic [LG_ROB_ENTRIES-1:0] div_rob_ptr_in;
    logic [LG_PRF_ENTRIES-1:0] div_prf_ptr_in;

    // Controller -> writeback arbiter
    logic                      wb_valid;
    logic                      wb_ack;
    logic [W-1:0]              wb_data;
    logic [LG_ROB_ENTRIES-1:0] wb_rob_ptr;
    logic [LG_PRF_ENTRIES-1:0] wb_prf_ptr;

    modport slave (
        input  enq_valid, enq_srcA, enq_srcB, enq_signed, enq_rem, enq_rob_ptr, enq_prf_ptr,
        output enq_ready,
        output start_div, div_srcA, div_srcB, div_is_signed, div_is_rem, div_rob_ptr, div_prf_ptr,
        input  div_complete, div_y, div_rob_ptr_in, div_prf_ptr_in,
        output wb_valid, wb_data, wb_rob_ptr, wb_prf_ptr,
        input  wb_ack
    );

    modport master (
        output enq_valid, enq_srcA, enq_srcB, enq_signed, enq_rem, enq_rob_ptr, enq_prf_ptr,
        input  enq_ready,
        input  start_div, div_srcA, div_srcB, div_is_signed, div_is_rem, div_rob_ptr, div_prf_ptr,
        output div_complete, div_y, div_rob_ptr_in, div_prf_ptr_in,
        input  wb_valid, wb_data, wb_rob_ptr, wb_prf_ptr,
        output wb_ack
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issue/retire controller for the iterative integer divider.
// Uops are queued in order, issued one at a time to the divider, and results
// are parked in a two-entry buffer for the writeback arbiter. A zero divisor
// never reaches the divider: its RISC-V result (all-ones quotient, dividend
// as remainder) is produced directly from the queue head.
module div_issue_ctrl #(
    parameter int LG_W           = 5,
    parameter int LG_Q           = 2,
    parameter int LG_ROB_ENTRIES = 6,
    parameter int LG_PRF_ENTRIES = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    div_issue_ctrl_if.slave bus
);
    localparam int W = 1 << LG_W;
    localparam int Q = 1 << LG_Q;
    localparam logic [LG_Q:0] Q_FULL = (LG_Q+1)'(Q);

    typedef struct packed {
        logic [W-1:0]              srcA;
        logic [W-1:0]              srcB;
        logic                      is_signed;
        logic                      is_rem;
        logic [LG_ROB_ENTRIES-1:0] rob;
        logic [LG_PRF_ENTRIES-1:0] prf;
    } uop_t;

    typedef struct packed {
        logic [W-1:0]              data;
        logic [LG_ROB_ENTRIES-1:0] rob;
        logic [LG_PRF_ENTRIES-1:0] prf;
    } res_t;

    // Input queue state
    uop_t            w_q_ent [Q];
    logic [LG_Q-1:0] r_q_head;
    logic [LG_Q-1:0] r_q_tail;
    logic [LG_Q:0]   r_q_count;

    // Result buffer state
    res_t       w_rb_ent [2];
    logic       r_rb_head;
    logic       r_rb_tail;
    logic [1:0] r_rb_count;

    // Divider tracking: one op at most is in the divider; killed marks an op
    // whose result must be thrown away because a flush overtook it.
    logic r_inflight;
    logic r_killed;

    uop_t w_enq_uop;
    uop_t w_head;
    res_t w_rb_in;
    res_t w_rb_head;
    logic w_q_push;
    logic w_q_pop;
    logic w_can_issue;
    logic w_issue_div;
    logic w_issue_zero;
    logic w_cmp_push;
    logic w_rb_push;
    logic w_rb_pop;
    logic w_unused_div_y;

    assign w_enq_uop = {bus.enq_srcA, bus.enq_srcB, bus.enq_signed, bus.enq_rem,
                        bus.enq_rob_ptr, bus.enq_prf_ptr};
    assign w_head    = w_q_ent[r_q_head];
    assign w_rb_head = w_rb_ent[r_rb_head];

    // The divider result is double width; only the low half carries the answer.
    assign w_unused_div_y = &{1'b0, bus.div_y[2*W-1:W]};

    // enq_ready looks only at the registered count so it never waits on a pop.
    assign w_q_push = bus.enq_valid && bus.enq_ready && !flush;

    // Issue needs an idle divider and guaranteed room for the result. Both
    // paths share this gate, so a completion can never meet a full buffer.
    assign w_can_issue  = (r_q_count != '0) && !r_inflight && (r_rb_count < 2'd2) && !flush;
    assign w_issue_div  = w_can_issue && (w_head.srcB != '0);
    assign w_issue_zero = w_can_issue && (w_head.srcB == '0);
    assign w_q_pop      = w_can_issue;

    assign w_cmp_push = bus.div_complete && r_inflight && !r_killed && !flush;
    assign w_rb_push  = w_issue_zero || w_cmp_push;
    assign w_rb_pop   = (r_rb_count != 2'd0) && bus.wb_ack && !flush;

    // Select the result-buffer source: zero-divisor shortcut or divider return
    always_comb begin
        w_rb_in = {bus.div_y[W-1:0], bus.div_rob_ptr_in, bus.div_prf_ptr_in};
        if (w_issue_zero) begin
            w_rb_in = {(w_head.is_rem ? w_head.srcA : {W{1'b1}}), w_head.rob, w_head.prf};
        end
    end

    genvar gi;

    // Queue storage: one register slot per entry, written when it is the tail
    for (gi = 0; gi < Q; gi++) begin : g_q_ent
        uop_t r_ent;
        // Capture the incoming uop into this slot
        always_ff @(posedge clk) begin
            if (reset) begin
                r_ent <= '0;
            end else if (w_q_push && (r_q_tail == LG_Q'(gi))) begin
                r_ent <= w_enq_uop;
            end
        end
        assign w_q_ent[gi] = r_ent;
    end

    // Result buffer storage: two slots, written when it is the tail
    for (gi = 0; gi < 2; gi++) begin : g_rb_ent
        res_t r_ent;
        // Capture a finished result into this slot
        always_ff @(posedge clk) begin
            if (reset) begin
                r_ent <= '0;
            end else if (w_rb_push && (r_rb_tail == 1'(gi))) begin
                r_ent <= w_rb_in;
            end
        end
        assign w_rb_ent[gi] = r_ent;
    end

    // Queue pointers and occupancy; flush empties the queue
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_q_head  <= '0;
            r_q_tail  <= '0;
            r_q_count <= '0;
        end else begin
            if (w_q_push) r_q_tail <= r_q_tail + LG_Q'(1);
            if (w_q_pop)  r_q_head <= r_q_head + LG_Q'(1);
            case ({w_q_push, w_q_pop})
                2'b10:   r_q_count <= r_q_count + (LG_Q+1)'(1);
                2'b01:   r_q_count <= r_q_count - (LG_Q+1)'(1);
                default: r_q_count <= r_q_count;
            endcase
        end
    end

    // Result buffer pointers and occupancy; flush empties the buffer
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rb_head  <= 1'b0;
            r_rb_tail  <= 1'b0;
            r_rb_count <= 2'd0;
        end else begin
            if (w_rb_push) r_rb_tail <= ~r_rb_tail;
            if (w_rb_pop)  r_rb_head <= ~r_rb_head;
            case ({w_rb_push, w_rb_pop})
                2'b10:   r_rb_count <= r_rb_count + 2'd1;
                2'b01:   r_rb_count <= r_rb_count - 2'd1;
                default: r_rb_count <= r_rb_count;
            endcase
        end
    end

    // Track the op in the divider; a flush while it runs marks it killed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_killed   <= 1'b0;
        end else begin
            if (bus.div_complete) begin
                r_inflight <= 1'b0;
                r_killed   <= 1'b0;
            end else if (w_issue_div) begin
                r_inflight <= 1'b1;
            end
            if (flush && r_inflight && !bus.div_complete) begin
                r_killed <= 1'b1;
            end
        end
    end

    // Completion must never find the result buffer full
    a_rb_space: assert property (@(posedge clk) disable iff (reset)
        !(bus.div_complete && r_inflight && !r_killed && !flush && (r_rb_count == 2'd2)));

    assign bus.enq_ready     = (r_q_count != Q_FULL);
    assign bus.start_div     = w_issue_div;
    assign bus.div_srcA      = w_head.srcA;
    assign bus.div_srcB      = w_head.srcB;
    assign bus.div_is_signed = w_head.is_signed;
    assign bus.div_is_rem    = w_head.is_rem;
    assign bus.div_rob_ptr   = w_head.rob;
    assign bus.div_prf_ptr   = w_head.prf;

    assign bus.wb_valid   = (r_rb_count != 2'd0);
    assign bus.wb_data    = w_rb_head.data;
    assign bus.wb_rob_ptr = w_rb_head.rob;
    assign bus.wb_prf_ptr = w_rb_head.prf;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural iterative divider that
// completes W+2 cycles after start_div, and a writeback collector.
module tb_div_issue_ctrl;
    localparam int LG_W   = 5;
    localparam int W      = 32;
    localparam int LG_ROB = 6;
    localparam int LG_PRF = 7;

    typedef struct {
        logic [W-1:0]      data;
        logic [LG_ROB-1:0] rob;
        logic [LG_PRF-1:0] prf;
        int                c;
    } wb_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   cyc   = 0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_start  = 0;
    int n_cmp    = 0;
    int acc_cyc  = 0;
    int start_cyc_q[$];
    wb_t wb_q[$];

    div_issue_ctrl_if #(.LG_W(LG_W), .LG_ROB_ENTRIES(LG_ROB), .LG_PRF_ENTRIES(LG_PRF)) bus ();

    div_issue_ctrl #(
        .LG_W(LG_W), .LG_Q(2), .LG_ROB_ENTRIES(LG_ROB), .LG_PRF_ENTRIES(LG_PRF)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic wb_t wb_at(input int i);
        wb_t d;
        d.data = 'x; d.rob = 'x; d.prf = 'x; d.c = 1 << 30;
        if (i < wb_q.size()) d = wb_q[i];
        return d;
    endfunction

    function automatic int start_at(input int i);
        return (i < start_cyc_q.size()) ? start_cyc_q[i] : -(1 << 20);
    endfunction

    // Behavioural divider result (RISC-V semantics for non-zero divisor)
    function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s, input logic r);
        longint la, lb, q, m;
        if (b == '0) return 32'hDEAD_BEEF;
        la = s ? longint'($signed(a)) : longint'(a);
        lb = s ? longint'($signed(b)) : longint'(b);
        q = la / lb;
        m = la % lb;
        return r ? m[W-1:0] : q[W-1:0];
    endfunction

    // Divider model and writeback collector, acting just after each negedge
    initial begin : env
        logic              busy;
        int                k;
        logic [W-1:0]      res;
        logic [LG_ROB-1:0] rob_r;
        logic [LG_PRF-1:0] prf_r;
        wb_t               w;
        busy = 1'b0; k = 0; res = '0; rob_r = '0; prf_r = '0;
        bus.div_complete = 1'b0;
        bus.div_y = '0;
        bus.div_rob_ptr_in = '0;
        bus.div_prf_ptr_in = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.div_complete = 1'b0;
            if (reset) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    k--;
                    if (k == 0) begin
                        busy = 1'b0;
                        bus.div_complete = 1'b1;
                        bus.div_y = {32'hA5A5_5A5A, res};
                        bus.div_rob_ptr_in = rob_r;
                        bus.div_prf_ptr_in = prf_r;
                        n_cmp++;
                    end
                end
                if (bus.start_div) begin
                    busy  = 1'b1;
                    k     = W + 2;
                    res   = ref_div(bus.div_srcA, bus.div_srcB, bus.div_is_signed, bus.div_is_rem);
                    rob_r = bus.div_rob_ptr;
                    prf_r = bus.div_prf_ptr;
                    n_start++;
                    start_cyc_q.push_back(cyc);
                end
                if (bus.wb_valid && bus.wb_ack && !flush) begin
                    w.data = bus.wb_data; w.rob = bus.wb_rob_ptr; w.prf = bus.wb_prf_ptr; w.c = cyc;
                    wb_q.push_back(w);
                    $display("wb: data=0x%08h rob=%0d prf=%0d cyc=%0d", w.data, w.rob, w.prf, w.c);
                end
            end
        end
    end

    // Offer one uop from a negedge until accepted; returns at a negedge
    task automatic enq(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic r, input logic [LG_ROB-1:0] rob, input logic [LG_PRF-1:0] prf);
        int t = 0;
        bus.enq_srcA = a; bus.enq_srcB = b; bus.enq_signed = s; bus.enq_rem = r;
        bus.enq_rob_ptr = rob; bus.enq_prf_ptr = prf; bus.enq_valid = 1'b1;
        while (!bus.enq_ready && t < 300) begin @(negedge clk); t++; end
        if (t >= 300) check("enq_accept_timeout", bus.enq_ready, 1);
        acc_cyc = cyc;
        $display("enq: a=0x%08h b=0x%08h s=%0d r=%0d rob=%0d cyc=%0d", a, b, s, r, rob, cyc);
        @(negedge clk);
        bus.enq_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int n, input int budget);
        int t = 0;
        while (wb_q.size() < n && t < budget) begin @(negedge clk); t++; end
        check(tag, wb_q.size(), n);
    endtask

    task automatic wait_start(input int n, input int budget);
        int t = 0;
        while (n_start < n && t < budget) begin @(negedge clk); t++; end
        check("wait_start", n_start, n);
    endtask

    initial begin : main
        int sb, rb, cb, a0, s0, t;
        logic [W-1:0] exp4 [6];
        bus.enq_valid = 1'b0; bus.enq_srcA = '0; bus.enq_srcB = '0; bus.enq_signed = 1'b0;
        bus.enq_rem = 1'b0; bus.enq_rob_ptr = '0; bus.enq_prf_ptr = '0; bus.wb_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_enq_ready", bus.enq_ready, 1);
        check("rst_start_div", bus.start_div, 0);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_div_srcA", bus.div_srcA, 0);

        // Unsigned quotient then remainder, back to back
        bus.wb_ack = 1'b1;
        sb = n_start; rb = wb_q.size();
        enq(100, 7, 1'b0, 1'b0, 6'd1, 7'd10);
        enq(100, 7, 1'b0, 1'b1, 6'd2, 7'd11);
        wait_res("t1_wait", rb + 2, 200);
        check("t1_quot", wb_at(rb).data, 14);
        check("t1_quot_rob", wb_at(rb).rob, 1);
        check("t1_quot_prf", wb_at(rb).prf, 10);
        check("t1_rem", wb_at(rb + 1).data, 2);
        check("t1_rem_rob", wb_at(rb + 1).rob, 2);
        check("t1_rem_prf", wb_at(rb + 1).prf, 11);
        check("t1_latency", wb_at(rb).c - start_at(sb), W + 3);
        check("t1_start_gap_ok", (start_at(sb + 1) - start_at(sb)) >= W + 3, 1);

        // Signed remainder and signed overflow division
        rb = wb_q.size();
        enq(32'hFFFF_FFF9, 3, 1'b1, 1'b1, 6'd3, 7'd12);
        enq(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 6'd4, 7'd13);
        wait_res("t2_wait", rb + 2, 200);
        check("t2_srem", wb_at(rb).data, 32'hFFFF_FFFF);
        check("t2_sdiv_ovf", wb_at(rb + 1).data, 32'h8000_0000);
        check("t2_sdiv_rob", wb_at(rb + 1).rob, 4);

        // Divide by zero fast path
        sb = n_start; rb = wb_q.size();
        enq(32'hFFFF_FFFB, 0, 1'b1, 1'b0, 6'd5, 7'd14);
        a0 = acc_cyc;
        wait_res("t3_wait_div", rb + 1, 10);
        check("t3_zdiv", wb_at(rb).data, 32'hFFFF_FFFF);
        check("t3_zdiv_fast", (wb_at(rb).c - a0) <= 3, 1);
        enq(32'hFFFF_FFFB, 0, 1'b1, 1'b1, 6'd6, 7'd15);
        a0 = acc_cyc;
        wait_res("t3_wait_rem", rb + 2, 10);
        check("t3_zrem", wb_at(rb + 1).data, 32'hFFFF_FFFB);
        check("t3_zrem_prf", wb_at(rb + 1).prf, 15);
        check("t3_zrem_fast", (wb_at(rb + 1).c - a0) <= 3, 1);
        check("t3_no_start", n_start - sb, 0);

        // Queue fills while the divider is busy; fifth uop waits for a dispatch
        sb = n_start; rb = wb_q.size();
        enq(50, 5, 1'b0, 1'b0, 6'd20, 7'd20);
        wait_start(sb + 1, 10);
        enq(9, 2, 1'b0, 1'b0, 6'd21, 7'd21);
        enq(9, 2, 1'b0, 1'b1, 6'd22, 7'd22);
        enq(16, 0, 1'b0, 1'b0, 6'd23, 7'd23);
        enq(1000, 10, 1'b0, 1'b0, 6'd24, 7'd24);
        check("t4_full_ready_low", bus.enq_ready, 0);
        check("t4_held_starts", n_start - sb, 1);
        enq(7, 0, 1'b0, 1'b1, 6'd25, 7'd25);
        check("t4_accept_after_dispatch", n_start - sb, 2);
        wait_res("t4_wait", rb + 6, 400);
        exp4 = '{32'd10, 32'd4, 32'd1, 32'hFFFF_FFFF, 32'd100, 32'd7};
        for (int i = 0; i < 6; i++) check($sformatf("t4_data%0d", i), wb_at(rb + i).data, exp4[i]);
        check("t4_last_rob", wb_at(rb + 5).rob, 25);

        // Writeback stall: two buffered results block further issue
        bus.wb_ack = 1'b0;
        sb = n_start; rb = wb_q.size();
        enq(20, 4, 1'b0, 1'b0, 6'd30, 7'd30);
        enq(6, 0, 1'b0, 1'b0, 6'd31, 7'd31);
        enq(30, 3, 1'b0, 1'b0, 6'd32, 7'd32);
        enq(8, 0, 1'b0, 1'b1, 6'd33, 7'd33);
        repeat (80) @(negedge clk);
        check("t5_stall_starts", n_start - sb, 1);
        check("t5_stall_valid", bus.wb_valid, 1);
        check("t5_stall_data", bus.wb_data, 5);
        check("t5_stall_rob", bus.wb_rob_ptr, 30);
        check("t5_stall_no_pop", wb_q.size() - rb, 0);
        check("t5_stall_queue_room", bus.enq_ready, 1);
        bus.wb_ack = 1'b1;
        wait_res("t5_wait", rb + 4, 200);
        check("t5_data0", wb_at(rb).data, 5);
        check("t5_data1", wb_at(rb + 1).data, 32'hFFFF_FFFF);
        check("t5_data2", wb_at(rb + 2).data, 10);
        check("t5_data3", wb_at(rb + 3).data, 8);
        check("t5_starts", n_start - sb, 2);

        // Flush while an op is in the divider with two more queued
        sb = n_start; rb = wb_q.size(); cb = n_cmp;
        enq(77, 7, 1'b0, 1'b0, 6'd40, 7'd40);
        enq(10, 2, 1'b0, 1'b0, 6'd41, 7'd41);
        enq(12, 3, 1'b0, 1'b0, 6'd42, 7'd42);
        wait_start(sb + 1, 10);
        s0 = start_at(sb);
        t = 0;
        while (cyc < s0 + 5 && t < 20) begin @(negedge clk); t++; end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t6_flush_wb_valid", bus.wb_valid, 0);
        check("t6_flush_ready", bus.enq_ready, 1);
        enq(81, 9, 1'b0, 1'b0, 6'd43, 7'd43);
        wait_res("t6_wait", rb + 1, 150);
        repeat (5) @(negedge clk);
        check("t6_one_result", wb_q.size() - rb, 1);
        check("t6_post_flush_data", wb_at(rb).data, 9);
        check("t6_post_flush_rob", wb_at(rb).rob, 43);
        check("t6_starts", n_start - sb, 2);
        check("t6_completions", n_cmp - cb, 2);

        // Reset in the middle of a division
        sb = n_start;
        enq(99, 3, 1'b0, 1'b0, 6'd50, 7'd50);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rb = wb_q.size();
        check("t7_rst_wb_valid", bus.wb_valid, 0);
        check("t7_rst_enq_ready", bus.enq_ready, 1);
        check("t7_rst_start_div", bus.start_div, 0);
        check("t7_rst_div_srcA", bus.div_srcA, 0);
        repeat (60) @(negedge clk);
        check("t7_no_stale_result", wb_q.size() - rb, 0);
        enq(45, 9, 1'b0, 1'b0, 6'd51, 7'd51);
        wait_res("t7_wait", rb + 1, 100);
        check("t7_recover_data", wb_at(rb).data, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
